dt_stats: RTL and testbench
===========================

# dt_stats

Post-processing stage downstream of the distance-transform engine. After the engine asserts `done`, this block is started and sweeps the 128x128 result RAM (16384 x 8-bit) with its own read port. It reports the maximum distance value, the lowest address holding that maximum, and the count of non-zero (object) pixels. It only reads the RAM and never writes it; the RAM read port is muxed to this block by the top level once the engine is finished.

## Interface
- `ADDR_W`, default 14: result RAM address width.
- `DATA_W`, default 8: result pixel width.
- `NPIX`, default 16384: pixels swept, addresses 0..NPIX-1.
- `clk` in 1: single clock, rising-edge logic.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: begin a sweep; sampled at rising edge in IDLE or DONE.
- `res_rd` out 1: RAM read enable. The RAM reads at `negedge clk`.
- `res_addr` out ADDR_W: RAM read address.
- `res_di` in DATA_W: RAM read data, valid on the rising edge after the address was issued.
- `busy` out 1: high while RUN.
- `done` out 1: level, high in DONE until the next accepted `start`.
- `max_val` out DATA_W: maximum pixel value.
- `max_addr` out ADDR_W: lowest address where `max_val` occurs.
- `obj_cnt` out ADDR_W+1: number of pixels that are != 0. Range 0..16384.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on `start`.
- RUN -> DONE after the last pixel is captured.
- DONE -> RUN on `start`. Otherwise the block holds.
- Accepted `start`:
  - clears the accumulators (`max_val`=0, `max_addr`=0, `obj_cnt`=0);
  - clears `done`;
  - issues address 0 with `res_rd`=1.
- RUN issues one address per cycle, incrementing from 0 to NPIX-1, then deasserts `res_rd`.
- Capture: a one-cycle-delayed valid flag qualifies `res_di`. Pixel k is captured on the edge after address k is issued.
- Per captured pixel p at address a:
  - if p > `max_val` (strictly greater), then `max_val`<=p and `max_addr`<=a. Ties keep the earlier, lower address.
  - if p != 0, then `obj_cnt`++.
- Widths:
  - the address counter does not wrap inside a sweep; it stops at NPIX-1;
  - `obj_cnt` is ADDR_W+1 bits, so 16384 fits without overflow.
- `start` while RUN is ignored; the sweep is not restarted.
- Outputs are stable in DONE and IDLE.
- Reset mid-sweep: all registers return to reset values immediately, `res_rd` drops asynchronously, and the block goes to IDLE. No partial results are retained.

## Timing
- Reset values:
  - `res_rd`=0, `res_addr`=0;
  - `busy`=0, `done`=0;
  - `max_val`=0, `max_addr`=0, `obj_cnt`=0;
  - (`sum_val`=0 when enabled); state IDLE.
- Edge T0 samples `start`=1. After T0: `res_rd`=1, `res_addr`=0, `busy`=1.
- After edge Tk: `res_addr`=k, for k = 0..16383.
- Edge T(k+1) captures pixel k.
- Edge T16384 captures pixel 16383 and ends the sweep. After T16384: `res_rd`=0, `busy`=0, `done`=1, and all results final.
- Latency: 16384 cycles from the `start` edge to `done`. Throughput: 1 pixel/cycle.
- All outputs are registered. No combinational path from `res_di` to any output.

## Configuration
- `DT_STATS_SUM_EN` defined:
  - adds output `sum_val` out 22 bits, the sum of all pixels (max 16384*255 < 2^22, no overflow);
  - `sum_val` is cleared on `start`, accumulated per captured pixel, and valid with `done`.
- `DT_STATS_SUM_EN` undefined: the port and adder are absent. All other behaviour is identical.

## Test plan
- All-zero RAM, `start` pulse:
  - `done` rises exactly 16384 cycles after the start edge;
  - `max_val`=0, `max_addr`=0, `obj_cnt`=0 (`sum_val`=0).
- RAM[5]=3, RAM[9000]=7, RAM[12000]=7, others 1:
  - `max_val`=7, `max_addr`=9000 (tie resolves to the lower address), `obj_cnt`=16384;
  - `sum_val`=16384-3+3+7+7=16398.
- RAM[16383]=0xFF, others 0:
  - `max_val`=0xFF, `max_addr`=16383, `obj_cnt`=1, confirming the last pixel is captured.
- `start` pulsed again at cycle 100 of a sweep:
  - ignored; `done` still at cycle 16384 with results identical to the single-start run.
- `reset` low at cycle 5000 mid-sweep:
  - `res_rd`=0 and `busy`=0 immediately, all outputs 0;
  - a new `start` then gives a full correct sweep.
- Back-to-back: `start` in DONE after changing RAM[0]=9:
  - `done` drops after the start edge;
  - the new sweep reports `max_val`=9, `max_addr`=0 with freshly cleared counts.

Source files
------------

// File: rtl/dt_stats.sv
// dt_stats: statistics sweep over the 128x128 distance-transform result RAM.
// Reports the maximum pixel value, the lowest address holding it, and the
// number of non-zero (object) pixels. Reads only; never writes the RAM.
// Optional feature: define DT_STATS_SUM_EN to add o_sum_val (sum of all pixels).
module dt_stats #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int NPIX   = 16384
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_res_rd,
    output logic [ADDR_W-1:0] o_res_addr,
    input  logic [DATA_W-1:0] i_res_di,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_max_val,
    output logic [ADDR_W-1:0] o_max_addr,
`ifdef DT_STATS_SUM_EN
    output logic [21:0]       o_sum_val,
`endif
    output logic [ADDR_W:0]   o_obj_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_cap;
    logic                w_last;

    logic                r_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_max_val;
    logic [ADDR_W-1:0]   r_max_addr;
    logic [ADDR_W:0]     r_obj_cnt;
`ifdef DT_STATS_SUM_EN
    logic [21:0]         r_sum_val;
`endif

    // State register: asynchronous reset returns the sweep to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is honoured only outside RUN; RUN ends on the last capture.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
                else         w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_state_nxt = S_RUN;
            end
            S_DONE: begin
                if (i_start) w_state_nxt = S_RUN;
                else         w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control decode: r_rd doubles as the one-cycle-delayed valid flag, since the
    // data on i_res_di at a rising edge belongs to the address issued the edge before.
    always_comb begin
        w_accept = 1'b0;
        w_cap    = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = i_start;
            end
            S_RUN: begin
                w_cap  = r_rd;
                w_last = r_rd && (r_addr == LAST_ADDR);
            end
            S_DONE: begin
                w_accept = i_start;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    // Datapath: address generation, capture and accumulation, registered status flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_max_val  <= '0;
            r_max_addr <= '0;
            r_obj_cnt  <= '0;
`ifdef DT_STATS_SUM_EN
            r_sum_val  <= 22'd0;
`endif
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_rd       <= 1'b1;
                r_addr     <= '0;
                r_max_val  <= '0;
                r_max_addr <= '0;
                r_obj_cnt  <= '0;
`ifdef DT_STATS_SUM_EN
                r_sum_val  <= 22'd0;
`endif
            end else if (w_cap) begin
                // Strictly greater keeps the first (lowest) address on ties.
                if (i_res_di > r_max_val) begin
                    r_max_val  <= i_res_di;
                    r_max_addr <= r_addr;
                end
                if (i_res_di != '0) begin
                    r_obj_cnt <= r_obj_cnt + (ADDR_W+1)'(1);
                end
`ifdef DT_STATS_SUM_EN
                r_sum_val <= r_sum_val + 22'(i_res_di);
`endif
                // The counter stops at the last address instead of wrapping.
                if (w_last) begin
                    r_rd <= 1'b0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end else begin
                r_rd <= r_rd;
            end
        end
    end

    assign o_res_rd   = r_rd;
    assign o_res_addr = r_addr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_max_val  = r_max_val;
    assign o_max_addr = r_max_addr;
    assign o_obj_cnt  = r_obj_cnt;
`ifdef DT_STATS_SUM_EN
    assign o_sum_val  = r_sum_val;
`endif

endmodule

// File: tb/tb_dt_stats.sv
// Testbench for dt_stats: RAM model with negedge read, behavioural reference
// model of the sweep, per-cycle compare process and hand-computed checks.
module tb_dt_stats;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int NPIX   = 16384;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              res_rd;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_di;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] max_val;
    logic [ADDR_W-1:0] max_addr;
    logic [ADDR_W:0]   obj_cnt;
`ifdef DT_STATS_SUM_EN
    logic [21:0]       sum_val;
`endif

    logic [DATA_W-1:0] ram [NPIX];

    int n_vec;
    int n_err;
    bit chk_en;

    // reference model state
    bit m_run;
    bit m_done;
    int m_k;
    int m_max, m_maxa, m_cnt, m_sum;
    int f_max, f_maxa, f_cnt, f_sum;

    dt_stats #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .o_res_rd   (res_rd),
        .o_res_addr (res_addr),
        .i_res_di   (res_di),
        .o_busy     (busy),
        .o_done     (done),
        .o_max_val  (max_val),
        .o_max_addr (max_addr),
`ifdef DT_STATS_SUM_EN
        .o_sum_val  (sum_val),
`endif
        .o_obj_cnt  (obj_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port: registered read on the falling edge
    always @(negedge clk) begin
        if (res_rd) res_di <= ram[res_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: sweep position counted from the start edge; results from a whole-RAM scan
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_done = 1'b0; m_k = 0;
            m_max = 0; m_maxa = 0; m_cnt = 0; m_sum = 0;
        end else if (!m_run && start) begin
            m_run = 1'b1; m_done = 1'b0; m_k = 0;
            m_max = 0; m_maxa = 0; m_cnt = 0; m_sum = 0;
            f_max = 0; f_maxa = 0; f_cnt = 0; f_sum = 0;
            for (int a = 0; a < NPIX; a++) begin
                if (int'(ram[a]) > f_max) begin
                    f_max  = int'(ram[a]);
                    f_maxa = a;
                end
                if (ram[a] != 8'd0) f_cnt++;
                f_sum += int'(ram[a]);
            end
        end else if (m_run) begin
            if (m_k == NPIX - 1) begin
                m_run = 1'b0; m_done = 1'b1;
                m_max = f_max; m_maxa = f_maxa; m_cnt = f_cnt; m_sum = f_sum;
            end else begin
                m_k++;
            end
        end
    end

    // Compare process: every cycle, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_run));
            chk("res_rd", 32'(res_rd), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            if (m_run) begin
                chk("res_addr", 32'(res_addr), 32'(m_k));
            end else begin
                chk("max_val", 32'(max_val), 32'(m_max));
                chk("max_addr", 32'(max_addr), 32'(m_maxa));
                chk("obj_cnt", 32'(obj_cnt), 32'(m_cnt));
`ifdef DT_STATS_SUM_EN
                chk("sum_val", 32'(sum_val), 32'(m_sum));
`endif
                if (!m_done) chk("idle_addr", 32'(res_addr), 32'd0);
            end
        end
    end

    // Launch a sweep; optionally pulse start again at cycle restart_at; measure latency
    task automatic run_sweep(input int restart_at, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_clr", 32'(done), 32'd0);
        chk("busy_set", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 20000) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (lat == restart_at) start = 1'b1;
        end
        chk("latency", 32'(lat), 32'd16384);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        n_vec  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        start  = 1'b0;
        rst_n  = 1'b0;
        res_di = 8'd0;
        for (int a = 0; a < NPIX; a++) ram[a] = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", 32'(res_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_max", 32'(max_val), 32'd0);
        chk("rst_cnt", 32'(obj_cnt), 32'd0);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: all-zero RAM
        run_sweep(-1, lat);
        chk("t1_max", 32'(max_val), 32'd0);
        chk("t1_maxa", 32'(max_addr), 32'd0);
        chk("t1_cnt", 32'(obj_cnt), 32'd0);
`ifdef DT_STATS_SUM_EN
        chk("t1_sum", 32'(sum_val), 32'd0);
`endif

        // 2: ties at 7, extra start pulse at cycle 100 must be ignored
        for (int a = 0; a < NPIX; a++) ram[a] = 8'd1;
        ram[5] = 8'd3; ram[9000] = 8'd7; ram[12000] = 8'd7;
        run_sweep(100, lat);
        chk("t2_max", 32'(max_val), 32'd7);
        chk("t2_maxa", 32'(max_addr), 32'd9000);
        chk("t2_cnt", 32'(obj_cnt), 32'd16384);
`ifdef DT_STATS_SUM_EN
        chk("t2_sum", 32'(sum_val), 32'd16398);
`endif

        // 3: reset at cycle 5000 of a sweep, then a full sweep with only the last pixel set
        for (int a = 0; a < NPIX; a++) ram[a] = 8'd0;
        ram[NPIX-1] = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5000) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(res_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_max", 32'(max_val), 32'd0);
        chk("mid_rst_addr", 32'(res_addr), 32'd0);
        chk("mid_rst_cnt", 32'(obj_cnt), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_sweep(-1, lat);
        chk("t3_max", 32'(max_val), 32'd255);
        chk("t3_maxa", 32'(max_addr), 32'd16383);
        chk("t3_cnt", 32'(obj_cnt), 32'd1);

        // 4: back-to-back start from DONE with RAM[0]=9
        ram[NPIX-1] = 8'd0;
        ram[0] = 8'd9;
        run_sweep(-1, lat);
        chk("t4_max", 32'(max_val), 32'd9);
        chk("t4_maxa", 32'(max_addr), 32'd0);
        chk("t4_cnt", 32'(obj_cnt), 32'd1);
`ifdef DT_STATS_SUM_EN
        chk("t4_sum", 32'(sum_val), 32'd9);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
